// File: rtl/dctlb_missq.sv
// dctlb_missq: queue of outstanding DCTLB misses toward the L2 TLB, one small FSM per entry.
// Optional secondary-miss merging is enabled by defining DCTLB_MISSQ_MERGE_EN.
module dctlb_missq #(
    parameter int NENTRIES = 4,
    parameter int VPN_W    = 27,
    parameter int CTX_W    = 2,
    parameter int PPN_W    = 26,
    parameter int HPADDR_W = 11,
    localparam int ID_W    = $clog2(NENTRIES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                miss_valid,
    output logic                miss_retry,
    input  logic [VPN_W-1:0]    miss_vpn,
    input  logic [CTX_W-1:0]    miss_ctx,
    output logic                req_valid,
    input  logic                req_retry,
    output logic [VPN_W-1:0]    req_vpn,
    output logic [CTX_W-1:0]    req_ctx,
    output logic [ID_W-1:0]     req_id,
    input  logic                ack_valid,
    output logic                ack_retry,
    input  logic [ID_W-1:0]     ack_id,
    input  logic [PPN_W-1:0]    ack_ppn,
    input  logic [HPADDR_W-1:0] ack_hpaddr,
    input  logic                ack_fault,
    output logic                fill_valid,
    input  logic                fill_retry,
    output logic [VPN_W-1:0]    fill_vpn,
    output logic [CTX_W-1:0]    fill_ctx,
    output logic [PPN_W-1:0]    fill_ppn,
    output logic [HPADDR_W-1:0] fill_hpaddr,
    output logic                fill_fault,
    output logic [1:0]          fill_nmerge,
    output logic                missq_err
);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_SENT, S_FILL} state_e;

    state_e                state_q [NENTRIES];
    state_e                state_d [NENTRIES];
    logic                  err_d;
    logic [VPN_W-1:0]      vpn_q    [NENTRIES];
    logic [CTX_W-1:0]      ctx_q    [NENTRIES];
    logic [PPN_W-1:0]      ppn_q    [NENTRIES];
    logic [HPADDR_W-1:0]   hpaddr_q [NENTRIES];
    logic                  fault_q  [NENTRIES];

    logic                  any_idle, any_pend, any_fill;
    logic [ID_W-1:0]       alloc_idx, pend_idx, fill_idx;
    logic                  merge_hit, alloc_do, req_fire, fill_fire, ack_ok;

    // Descending scan so the lowest-index match is the one left standing.
    always_comb begin
        any_idle  = 1'b0;
        any_pend  = 1'b0;
        any_fill  = 1'b0;
        alloc_idx = '0;
        pend_idx  = '0;
        fill_idx  = '0;
        for (int i = NENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == S_IDLE) begin any_idle = 1'b1; alloc_idx = ID_W'(i); end
            if (state_q[i] == S_PEND) begin any_pend = 1'b1; pend_idx  = ID_W'(i); end
            if (state_q[i] == S_FILL) begin any_fill = 1'b1; fill_idx  = ID_W'(i); end
        end
    end

`ifdef DCTLB_MISSQ_MERGE_EN
    logic [ID_W-1:0] merge_idx;
    logic [1:0]      nmerge_q [NENTRIES];

    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
        for (int i = NENTRIES - 1; i >= 0; i--) begin
            if ((state_q[i] == S_PEND || state_q[i] == S_SENT) &&
                vpn_q[i] == miss_vpn && ctx_q[i] == miss_ctx) begin
                merge_hit = 1'b1;
                merge_idx = ID_W'(i);
            end
        end
    end

    // A merge into a SENT entry during its ack cycle still lands in the count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NENTRIES; i++) begin
            if ((alloc_do && alloc_idx == ID_W'(i)) || (fill_fire && fill_idx == ID_W'(i)))
                nmerge_q[i] <= 2'd0;
            else if (miss_valid && merge_hit && merge_idx == ID_W'(i) && nmerge_q[i] != 2'd3)
                nmerge_q[i] <= nmerge_q[i] + 2'd1;
        end
    end

    assign fill_nmerge = any_fill ? nmerge_q[fill_idx] : 2'd0;
`else
    assign merge_hit   = 1'b0;
    assign fill_nmerge = 2'd0;
`endif

    assign miss_retry = !any_idle && !merge_hit;
    assign alloc_do   = miss_valid && !merge_hit && any_idle;
    assign req_fire   = any_pend && !req_retry;
    assign fill_fire  = any_fill && !fill_retry;
    assign ack_ok     = ack_valid && state_q[ack_id] == S_SENT;

    // Each event targets an entry in a distinct state, so they never collide.
    always_comb begin
        err_d = missq_err || (ack_valid && !ack_ok);
        for (int i = 0; i < NENTRIES; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                S_IDLE: if (alloc_do && alloc_idx == ID_W'(i))   state_d[i] = S_PEND;
                S_PEND: if (req_fire && pend_idx == ID_W'(i))    state_d[i] = S_SENT;
                S_SENT: if (ack_valid && ack_id == ID_W'(i))     state_d[i] = S_FILL;
                S_FILL: if (fill_fire && fill_idx == ID_W'(i))   state_d[i] = S_IDLE;
                default:                                         state_d[i] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NENTRIES; i++) state_q[i] <= S_IDLE;
            missq_err <= 1'b0;
        end else begin
            for (int i = 0; i < NENTRIES; i++) state_q[i] <= state_d[i];
            missq_err <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_do) begin
            vpn_q[alloc_idx] <= miss_vpn;
            ctx_q[alloc_idx] <= miss_ctx;
        end
        if (ack_ok) begin
            ppn_q[ack_id]    <= ack_ppn;
            hpaddr_q[ack_id] <= ack_hpaddr;
            fault_q[ack_id]  <= ack_fault;
        end
    end

    assign ack_retry   = 1'b0;
    assign req_valid   = any_pend;
    assign req_id      = pend_idx;
    assign req_vpn     = any_pend ? vpn_q[pend_idx] : '0;
    assign req_ctx     = any_pend ? ctx_q[pend_idx] : '0;
    assign fill_valid  = any_fill;
    assign fill_vpn    = any_fill ? vpn_q[fill_idx]    : '0;
    assign fill_ctx    = any_fill ? ctx_q[fill_idx]    : '0;
    assign fill_ppn    = any_fill ? ppn_q[fill_idx]    : '0;
    assign fill_hpaddr = any_fill ? hpaddr_q[fill_idx] : '0;
    assign fill_fault  = any_fill ? fault_q[fill_idx]  : 1'b0;

endmodule
